// File: rtl/risc_pack.sv
// risc_pack: shared pipeline types for the qrisc32 core, including the memory-stage FSM states.
package risc_pack;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [4:0]  dst_r;
    logic [31:0] val_r1;
    logic [31:0] val_r2;
    logic [31:0] val_dst;
    logic        read_mem;
    logic        write_mem;
    logic        add_op;
    logic        sub_op;
    logic        and_op;
    logic        or_op;
    logic        jmp;
    logic        we_reg;
  } pipe_struct_t;
  typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;
  localparam pipe_struct_t PIPE_BUBBLE = '0;
endpackage

// File: rtl/qrisc32_wait_timer.sv
// qrisc32_wait_timer: saturating wait counter that flags when a bus request has waited its limit.
module qrisc32_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic areset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign expired = cnt >= CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (areset || clear) cnt <= '0;
    else if (enable && cnt != CW'(TIMEOUT_CYCLES)) cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/qrisc32_mem_stage.sv
// qrisc32_mem_stage: data-memory access stage with req/ack handshake, execute stall and bus timeout.
module qrisc32_mem_stage
  import risc_pack::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         areset,
  input  pipe_struct_t pipe_mem_in,
  output pipe_struct_t pipe_mem_out,
  output logic         pipe_stall,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [31:0]  dmem_addr,
  output logic [31:0]  dmem_wdata,
  input  logic [31:0]  dmem_rdata,
  input  logic         dmem_ack,
  output logic         bus_err
);
  mem_state_t   state, state_nx;
  pipe_struct_t done_pipe;
  logic         mem_op, start, expired;
  logic [31:0]  rdata_q;
  assign mem_op = pipe_mem_in.read_mem | pipe_mem_in.write_mem;
  assign start  = state == IDLE && mem_op;
  qrisc32_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .areset(areset),
    .clear(state == IDLE),
    .enable(state == REQ && !dmem_ack),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (areset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx   = state;
    pipe_stall = 1'b0;
    done_pipe  = pipe_mem_in;
    unique case (state)
      IDLE: begin
        pipe_stall = mem_op;
        state_nx   = mem_op ? REQ : IDLE;
      end
      REQ: begin
        pipe_stall = 1'b1;
        state_nx   = (dmem_ack || expired) ? DONE : REQ;
      end
      default: state_nx = IDLE;
    endcase
    // a load with the write bit also set is a store, so only pure loads take bus data
    done_pipe.val_dst = (pipe_mem_in.read_mem && !pipe_mem_in.write_mem) ? rdata_q : pipe_mem_in.val_dst;
  end
  always_ff @(posedge clk) begin
    if (areset) begin
      pipe_mem_out <= PIPE_BUBBLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      bus_err      <= 1'b0;
      rdata_q      <= '0;
    end else begin
      pipe_mem_out <= (state == DONE) ? done_pipe : (state == IDLE && !mem_op) ? pipe_mem_in : PIPE_BUBBLE;
      if (start) begin
        dmem_req   <= 1'b1;
        dmem_we    <= pipe_mem_in.write_mem;
        dmem_addr  <= pipe_mem_in.val_r1;
        dmem_wdata <= pipe_mem_in.val_dst;
      end
      if (state == REQ && dmem_ack) begin
        dmem_req <= 1'b0;
        if (!dmem_we) rdata_q <= dmem_rdata;
      end else if (state == REQ && expired) begin
        dmem_req <= 1'b0;
        bus_err  <= 1'b1;
        rdata_q  <= ERR_RDATA;
      end
    end
  end
endmodule

// File: tb/tb_qrisc32_mem_stage.sv
// tb_qrisc32_mem_stage: directed checks of pass-through, loads, stores, timeout and reset recovery.
module tb_qrisc32_mem_stage;
  import risc_pack::*;
  logic         clk, areset, ack;
  logic [31:0]  rdata;
  pipe_struct_t pin, pout, to_pout;
  logic         stall, req, we, bus_err;
  logic         to_stall, to_req, to_we, to_bus_err;
  logic [31:0]  addr, wdata, to_addr, to_wdata;
  int           checks = 0, errors = 0;
  qrisc32_mem_stage dut (
    .clk(clk), .areset(areset), .pipe_mem_in(pin), .pipe_mem_out(pout), .pipe_stall(stall),
    .dmem_req(req), .dmem_we(we), .dmem_addr(addr), .dmem_wdata(wdata),
    .dmem_rdata(rdata), .dmem_ack(ack), .bus_err(bus_err)
  );
  qrisc32_mem_stage #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .areset(areset), .pipe_mem_in(pin), .pipe_mem_out(to_pout), .pipe_stall(to_stall),
    .dmem_req(to_req), .dmem_we(to_we), .dmem_addr(to_addr), .dmem_wdata(to_wdata),
    .dmem_rdata(rdata), .dmem_ack(ack), .bus_err(to_bus_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  initial begin
    areset = 1'b1;
    ack    = 1'b1;
    rdata  = '0;
    pin    = '0;
    tick();
    tick();
    chk("rst_out", {31'd0, |pout}, 0);
    chk("rst_req", req, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_stall", stall, 0);
    areset = 1'b0;
    ack    = 1'b0;
    // ALU op passes straight through
    pin.add_op  = 1'b1;
    pin.val_dst = 32'h1234;
    pin.dst_r   = 5'd3;
    #1 chk("alu_stall", stall, 0);
    tick();
    chk("alu_val", pout.val_dst, 32'h1234);
    chk("alu_op", pout.add_op, 1);
    chk("alu_req", req, 0);
    // load, ack in first REQ cycle
    pin = '0;
    pin.read_mem = 1'b1;
    pin.val_r1   = 32'h100;
    pin.dst_r    = 5'd5;
    #1 chk("ld_stall0", stall, 1);
    tick();
    chk("ld_req", req, 1);
    chk("ld_addr", addr, 32'h100);
    chk("ld_we", we, 0);
    chk("ld_bub1", {31'd0, |pout}, 0);
    ack   = 1'b1;
    rdata = 32'hCAFE_BABE;
    #1 chk("ld_stall1", stall, 1);
    tick();
    ack = 1'b0;
    #1 chk("ld_stall2", stall, 0);
    chk("ld_req_drop", req, 0);
    chk("ld_bub2", {31'd0, |pout}, 0);
    tick();
    chk("ld_val", pout.val_dst, 32'hCAFE_BABE);
    chk("ld_rd", pout.read_mem, 1);
    chk("ld_dst", {27'd0, pout.dst_r}, 5);
    pin = '0;
    // store with 4 wait states
    pin.write_mem = 1'b1;
    pin.val_r1    = 32'h20;
    pin.val_dst   = 32'h55;
    #1 chk("st_stall0", stall, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("st_req", req, 1);
      chk("st_we", we, 1);
      chk("st_addr", addr, 32'h20);
      chk("st_wdata", wdata, 32'h55);
      chk("st_stall", stall, 1);
      chk("st_bub", {31'd0, |pout}, 0);
      if (i == 4) ack = 1'b1;
      tick();
    end
    ack = 1'b0;
    #1 chk("st_stall_done", stall, 0);
    chk("st_req_drop", req, 0);
    tick();
    chk("st_val", pout.val_dst, 32'h55);
    chk("st_wr", pout.write_mem, 1);
    pin = '0;
    // timeout on the 4-cycle instance
    areset = 1'b1;
    tick();
    areset = 1'b0;
    pin.read_mem = 1'b1;
    pin.val_r1   = 32'h40;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_req", to_req, 1);
      chk("to_err_pre", to_bus_err, 0);
      tick();
    end
    chk("to_req_drop", to_req, 0);
    chk("to_err", to_bus_err, 1);
    chk("to_stall_done", to_stall, 0);
    tick();
    chk("to_val", to_pout.val_dst, 32'hFFFF_FFFF);
    pin   = '0;
    ack   = 1'b1;
    rdata = 32'h1111_2222;
    tick();
    ack = 1'b0;
    chk("to_late_err", to_bus_err, 1);
    chk("to_late_req", to_req, 0);
    chk("to_late_out", to_pout.val_dst, 0);
    tick();
    chk("to_sticky", to_bus_err, 1);
    // reset in the middle of a wait, then a clean load
    areset = 1'b1;
    tick();
    areset = 1'b0;
    pin.read_mem = 1'b1;
    pin.val_r1   = 32'h80;
    tick();
    tick();
    chk("mr_req", req, 1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("mr_req_drop", req, 0);
    pin = '0;
    ack = 1'b1;
    #1 chk("mr_stall", stall, 0);
    tick();
    ack = 1'b0;
    chk("mr_ign_req", req, 0);
    chk("mr_ign_out", {31'd0, |pout}, 0);
    pin.read_mem = 1'b1;
    pin.val_r1   = 32'h84;
    tick();
    chk("mr2_req", req, 1);
    chk("mr2_addr", addr, 32'h84);
    ack   = 1'b1;
    rdata = 32'h600D_F00D;
    tick();
    ack = 1'b0;
    tick();
    chk("mr2_val", pout.val_dst, 32'h600D_F00D);
    chk("mr2_err", bus_err, 0);
    pin = '0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qrisc32_mem_stage.md
Name: qrisc32_mem_stage

Overview:
- Memory-access pipeline stage that sits directly downstream of the execute stage.
- Consumes the execute stage's registered pipe_struct_t output:
  - for read_mem/write_mem, val_r1 carries the effective address;
  - val_dst carries the store data.
- Runs a req/ack handshake to the data memory, returns load data in val_dst, and asserts a stall back to execute while an access is in flight.
- All other instructions pass through with one cycle of latency.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles a request may wait for dmem_ack before being aborted (must be ≥1).
- ERR_RDATA, 32'hFFFF_FFFF: value returned in val_dst for a load that timed out.

Ports:
- clk  in  1  single clock, rising edge.
- areset  in  1  reset, synchronous, active-high (named as elsewhere in the codebase; sampled only on posedge clk).
- pipe_mem_in  in  risc_pack::pipe_struct_t  instruction from execute (that stage's pipe_ex_out).
- pipe_mem_out  out  risc_pack::pipe_struct_t  registered instruction to write-back.
- pipe_stall  out  1  combinational; freezes execute (its pipe_stall input).
- dmem_req  out  1  registered bus request.
- dmem_we  out  1  registered; 1 = write.
- dmem_addr  out  32  registered word address.
- dmem_wdata  out  32  registered store data.
- dmem_rdata  in  32  load data, valid when dmem_ack = 1.
- dmem_ack  in  1  single-cycle completion strobe.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset (areset = 1 at posedge): state = IDLE; pipe_mem_out = '0; dmem_req/dmem_we = 0; dmem_addr/dmem_wdata = 0; bus_err = 0; timeout counter = 0.
  - Reset mid-access drops dmem_req on that same edge; any later ack is ignored.
- mem_op = pipe_mem_in.read_mem | pipe_mem_in.write_mem. If both bits are set, treat the access as a write.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - No mem_op: pipe_stall = 0; pipe_mem_out <= pipe_mem_in at the edge (1-cycle latency, no field modified).
  - mem_op: pipe_stall = 1; pipe_mem_out <= '0 (bubble). Register dmem_req = 1, dmem_we = write_mem, dmem_addr = val_r1, dmem_wdata = val_dst. Clear the counter; go to REQ.
- REQ:
  - pipe_stall = 1; pipe_mem_out <= '0. dmem_req and its address/data fields are held stable until ack.
  - dmem_ack = 1: capture dmem_rdata into rdata_q (loads only); dmem_req <= 0; go to DONE.
  - No ack: increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with no ack: dmem_req <= 0; bus_err <= 1; rdata_q <= ERR_RDATA; go to DONE.
  - Ack and the timeout limit in the same cycle: ack wins and bus_err is not set.
- DONE:
  - pipe_stall = 0.
  - pipe_mem_out <= pipe_mem_in, except val_dst <= rdata_q when read_mem is set and write_mem is clear. Stores pass val_dst unchanged.
  - Go to IDLE.
- Input stability: execute holds pipe_mem_in constant while pipe_stall = 1, so the DONE copy is the same instruction that was sampled in IDLE.
- Back-to-back memory ops: a new mem_op in IDLE right after DONE starts immediately.
  - Minimum occupancy is 3 cycles (IDLE, REQ with same-cycle ack, DONE).
  - Throughput is 1 access per 3 cycles plus wait states.
- dmem_ack outside REQ is ignored. bus_err is cleared only by areset.
- Counter width: $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- pipe_mem_out changes only at posedge clk and never emits a duplicate of an instruction.

Decomposition:
- risc_pack additions:
  - mem_state_t enum {IDLE, REQ, DONE};
  - localparam PIPE_BUBBLE = '0 of pipe_struct_t.
- The timeout counter is a natural sub-module: qrisc32_wait_timer (clear, enable, expired).
- The FSM, bus registers and output mux stay in the top module.

Test Plan:
- Reset: assert areset for 2 cycles with dmem_ack = 1 → all outputs 0, state IDLE, bus_err = 0.
- ALU pass-through: add_op with val_dst = 0x1234 → pipe_mem_out.val_dst = 0x1234 one cycle later; pipe_stall never asserted.
- Load, zero wait: read_mem, val_r1 = 0x100, ack with dmem_rdata = 0xCAFEBABE in the first REQ cycle → dmem_req high 1 cycle with dmem_addr = 0x100 and dmem_we = 0; pipe_stall high 2 cycles; pipe_mem_out.val_dst = 0xCAFEBABE on the 3rd edge; 2 bubbles precede it.
- Store, 4 wait states: write_mem, val_r1 = 0x20, val_dst = 0x55 → dmem_we = 1 and dmem_wdata = 0x55 held for 5 cycles; stall for 6 cycles; val_dst = 0x55 passes through.
- Timeout: TIMEOUT_CYCLES = 4, read with no ack → req drops after 4 REQ cycles; bus_err = 1 and stays 1; val_dst = 0xFFFFFFFF; a late ack is ignored.
- Reset mid-REQ: areset during wait → dmem_req = 0 next edge; the next load completes normally with correct data.
